// File: rtl/dll_pkg.sv
// Shared Data Link Layer definitions: DLCMSM states, TX beat kinds, frame widths.
// Latency: n/a (types, constants and pure framing helpers only).
// Backpressure: n/a.
// Contents: dlc_state_e, TX_KIND_*, TLP_W/DLLP_W/PIPE_W, framing and eligibility helpers.
package dll_pkg;

  typedef enum logic [1:0] {
    DL_INACTIVE = 2'b00,
    DL_FEATURE  = 2'b01,
    DL_INIT     = 2'b10,
    DL_ACTIVE   = 2'b11
  } dlc_state_e;

  localparam logic TX_KIND_TLP  = 1'b0;
  localparam logic TX_KIND_DLLP = 1'b1;

  localparam int TLP_W      = 128;
  localparam int DLLP_W     = 32;
  localparam int PIPE_W     = 136;
  localparam int LCRC_W     = 8;   // zero-filled LCRC field appended to every TLP
  localparam int DLLP_CRC_W = 16;  // zero-filled CRC field following the DLLP body

  // TLP beat: payload in the top 128 bits, zeroed LCRC slot underneath.
  function automatic logic [PIPE_W-1:0] frame_tlp(input logic [TLP_W-1:0] tlp);
    return {tlp, {LCRC_W{1'b0}}};
  endfunction

  // DLLP beat: body left-aligned, zeroed CRC, remainder of the beat zero.
  function automatic logic [PIPE_W-1:0] frame_dllp(input logic [DLLP_W-1:0] dllp);
    return {dllp, {DLLP_CRC_W{1'b0}}, {(PIPE_W-DLLP_W-DLLP_CRC_W){1'b0}}};
  endfunction

  // TLPs only flow once the link is fully up.
  function automatic logic tlp_eligible(input dlc_state_e st);
    return (st == DL_ACTIVE);
  endfunction

  // DLLPs are needed during flow-control init as well as in normal operation.
  function automatic logic dllp_eligible(input dlc_state_e st);
    return (st == DL_INIT) || (st == DL_ACTIVE);
  endfunction

endpackage

// File: rtl/dll_tx_arb.sv
// Burst-limited priority arbiter between TLP and DLLP requesters.
// Latency: grants are combinational; burst_cnt is registered.
// Backpressure: no grant unless load_ok_i (output slot free or draining); at most one grant per cycle.
// Ports: clk/rst; tlp_elig_i/dllp_elig_i from link state; tlp_valid_i/dllp_valid_i requests;
//        load_ok_i slot availability; tlp_gnt_o/dllp_gnt_o one-hot grants.
module dll_tx_arb
  import dll_pkg::*;
#(
  parameter int MAX_TLP_BURST = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic tlp_elig_i,
  input  logic dllp_elig_i,
  input  logic tlp_valid_i,
  input  logic dllp_valid_i,
  input  logic load_ok_i,
  output logic tlp_gnt_o,
  output logic dllp_gnt_o
);

  localparam int BCNT_W = $clog2(MAX_TLP_BURST + 1);
  localparam logic [BCNT_W-1:0] BCNT_MAX = BCNT_W'(MAX_TLP_BURST);

  logic [BCNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic              tlp_req, dllp_req, burst_max;

  assign tlp_req   = tlp_valid_i && tlp_elig_i;
  assign dllp_req  = dllp_valid_i && dllp_elig_i;
  assign burst_max = (burst_cnt_q == BCNT_MAX);

  // TLPs normally have priority; a pending DLLP takes the slot once the
  // TLP burst has reached its limit, or whenever no TLP is competing.
  // Grants are suppressed during reset so both readies stay low.
  always_comb begin
    dllp_gnt_o = 1'b0;
    tlp_gnt_o  = 1'b0;
    if (!rst && load_ok_i) begin
      if (dllp_req && (!tlp_req || burst_max)) begin
        dllp_gnt_o = 1'b1;
      end else if (tlp_req) begin
        tlp_gnt_o = 1'b1;
      end
    end
  end

  // Counts TLP grants taken while a DLLP is waiting. The count restarts as
  // soon as the DLLP side goes idle or is served, so the limit only bounds
  // how long a DLLP can be starved.
  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if (!dllp_valid_i || dllp_gnt_o) begin
      burst_cnt_d = '0;
    end else if (tlp_gnt_o && !burst_max) begin
      burst_cnt_d = burst_cnt_q + BCNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      burst_cnt_q <= '0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
    end
  end

endmodule

// File: rtl/dll_tx_sched.sv
// DLL transmit scheduler: arbitrates TLP/DLLP, frames the winner, assigns TLP sequence numbers.
// Latency: 1 cycle from grant to pipe_txvalid_o (registered output beat).
// Backpressure: valid/ready; new grants only when the output slot is empty or draining, full rate when ready stays high.
// Ports: clk, rst (sync, active-high); dlc_state_i link state; tlp_i/tlp_valid_i/tlp_ready_o TLP request;
//        dllp_i/dllp_valid_i/dllp_ready_o DLLP request; pipe_txdata_o/pipe_txvalid_o/pipe_txkind_o/pipe_txready_i
//        PHY beat; tlp_seq_o sequence of the TLP on the output; next_seq_o next sequence to assign.
module dll_tx_sched
  import dll_pkg::*;
#(
  parameter int MAX_TLP_BURST = 4,
  parameter int SEQ_W         = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        dlc_state_i,
  input  logic [TLP_W-1:0]  tlp_i,
  input  logic              tlp_valid_i,
  output logic              tlp_ready_o,
  input  logic [DLLP_W-1:0] dllp_i,
  input  logic              dllp_valid_i,
  output logic              dllp_ready_o,
  output logic [PIPE_W-1:0] pipe_txdata_o,
  output logic              pipe_txvalid_o,
  output logic              pipe_txkind_o,
  input  logic              pipe_txready_i,
  output logic [SEQ_W-1:0]  tlp_seq_o,
  output logic [SEQ_W-1:0]  next_seq_o
);

  dlc_state_e        state;
  logic              tlp_elig, dllp_elig, link_down, load_ok;
  logic              tlp_gnt, dllp_gnt;

  logic [PIPE_W-1:0] txdata_q, txdata_d;
  logic              txvalid_q, txvalid_d;
  logic              txkind_q, txkind_d;
  logic [SEQ_W-1:0]  txseq_q, txseq_d;
  logic [SEQ_W-1:0]  next_seq_q, next_seq_d;

  assign state     = dlc_state_e'(dlc_state_i);
  assign tlp_elig  = tlp_eligible(state);
  assign dllp_elig = dllp_eligible(state);
  assign link_down = (state == DL_INACTIVE);

  // Slot is free, or the held beat is leaving this cycle, so a new beat can
  // be loaded back-to-back without a bubble.
  assign load_ok = !txvalid_q || pipe_txready_i;

  dll_tx_arb #(
    .MAX_TLP_BURST (MAX_TLP_BURST)
  ) u_arb (
    .clk          (clk),
    .rst          (rst),
    .tlp_elig_i   (tlp_elig),
    .dllp_elig_i  (dllp_elig),
    .tlp_valid_i  (tlp_valid_i),
    .dllp_valid_i (dllp_valid_i),
    .load_ok_i    (load_ok),
    .tlp_gnt_o    (tlp_gnt),
    .dllp_gnt_o   (dllp_gnt)
  );

  assign tlp_ready_o  = tlp_gnt;
  assign dllp_ready_o = dllp_gnt;

  // Output register. A link drop discards whatever is held; otherwise a
  // beat stays put until the PHY takes it. tlp_seq is left untouched on a
  // DLLP load since it only has meaning for TLP beats.
  always_comb begin
    txdata_d  = txdata_q;
    txvalid_d = txvalid_q;
    txkind_d  = txkind_q;
    txseq_d   = txseq_q;
    if (link_down) begin
      txdata_d  = '0;
      txvalid_d = 1'b0;
      txkind_d  = TX_KIND_TLP;
      txseq_d   = '0;
    end else if (tlp_gnt) begin
      txdata_d  = frame_tlp(tlp_i);
      txvalid_d = 1'b1;
      txkind_d  = TX_KIND_TLP;
      txseq_d   = next_seq_q;
    end else if (dllp_gnt) begin
      txdata_d  = frame_dllp(dllp_i);
      txvalid_d = 1'b1;
      txkind_d  = TX_KIND_DLLP;
    end else if (load_ok) begin
      txvalid_d = 1'b0;
    end
  end

  // Sequence numbering restarts from zero every time the link (re)enters
  // DL_ACTIVE; the counter wraps naturally at 2^SEQ_W.
  always_comb begin
    next_seq_d = next_seq_q;
    if (state != DL_ACTIVE) begin
      next_seq_d = '0;
    end else if (tlp_gnt) begin
      next_seq_d = next_seq_q + SEQ_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      txdata_q   <= '0;
      txvalid_q  <= 1'b0;
      txkind_q   <= TX_KIND_TLP;
      txseq_q    <= '0;
      next_seq_q <= '0;
    end else begin
      txdata_q   <= txdata_d;
      txvalid_q  <= txvalid_d;
      txkind_q   <= txkind_d;
      txseq_q    <= txseq_d;
      next_seq_q <= next_seq_d;
    end
  end

  assign pipe_txdata_o  = txdata_q;
  assign pipe_txvalid_o = txvalid_q;
  assign pipe_txkind_o  = txkind_q;
  assign tlp_seq_o      = txseq_q;
  assign next_seq_o     = next_seq_q;

endmodule

// File: doc/dll_tx_sched.md
# dll_tx_sched

Transmit scheduler for the Data Link Layer. It arbitrates between TLPs from the Transaction Layer and DLLPs from the DLL control logic (Ack/Nak, InitFC/UpdateFC), gated by the DLCMSM state. It frames the winner into a registered 136-bit PIPE beat with valid/ready backpressure and assigns the 12-bit TLP sequence number. It sits between the Transaction Layer / DLL control and the PHY TX interface, and replaces direct TLP passthrough to the PHY.

## Interface
- MAX_TLP_BURST, default 4: maximum consecutive TLP grants while a DLLP is pending.
- SEQ_W, default 12: sequence-number width.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- dlc_state_i  in  2  DLCMSM state: 00 DL_INACTIVE, 01 DL_FEATURE, 10 DL_INIT, 11 DL_ACTIVE.
- tlp_i  in  128  TLP beat.
- tlp_valid_i  in  1  TLP request.
- tlp_ready_o  out  1  TLP accepted this cycle when high together with tlp_valid_i.
- dllp_i  in  32  DLLP body.
- dllp_valid_i  in  1  DLLP request.
- dllp_ready_o  out  1  DLLP accepted this cycle when high together with dllp_valid_i.
- pipe_txdata_o  out  136  framed beat.
- pipe_txvalid_o  out  1  beat valid.
- pipe_txkind_o  out  1  0 = TLP, 1 = DLLP.
- pipe_txready_i  in  1  PHY accepts the beat.
- tlp_seq_o  out  SEQ_W  sequence number carried by the beat currently on pipe_txdata_o (meaningful when kind = 0).
- next_seq_o  out  SEQ_W  next sequence number to be assigned.

## Operation
- **Eligibility:**
  - TLP is eligible only in DL_ACTIVE.
  - DLLP is eligible in DL_INIT or DL_ACTIVE.
  - Neither is eligible in DL_INACTIVE or DL_FEATURE.
- **Load condition:** `load_ok = !pipe_txvalid_o || pipe_txready_i`. This is the output-register slot free or draining this cycle.
- **Arbitration** (combinational, evaluated only when load_ok):
  - DLLP wins if it is eligible and valid, and either no eligible TLP is valid or burst_cnt == MAX_TLP_BURST.
  - Otherwise an eligible, valid TLP wins.
  - At most one ready is high per cycle.
- **burst_cnt:**
  - Width $clog2(MAX_TLP_BURST+1).
  - Increments on each TLP grant while dllp_valid_i is high.
  - Clears on a DLLP grant, or on any cycle in which dllp_valid_i is low.
  - Saturates at MAX_TLP_BURST.
- **TLP framing:** [135:8] = tlp_i, [7:0] = 8'h00 (dummy LCRC). kind = 0. tlp_seq_o = next_seq_o at the time of grant.
- **DLLP framing:** [135:104] = dllp_i, [103:88] = 16'h0000 (dummy CRC), [87:0] = 0. kind = 1.
- **Sequence counter:**
  - Increments by 1 per TLP grant.
  - Wraps 4095 → 0 (modulo 2^SEQ_W).
  - Held at 0 whenever dlc_state_i != DL_ACTIVE.
- **Requester rule:** a requester must hold valid and data stable until ready. The block does not depend on this for correctness.
- **Link drop:** in any cycle with dlc_state_i == DL_INACTIVE, the output register clears (pipe_txvalid_o = 0 next cycle) and no grants are issued. A beat already held is discarded.
- **DL_ACTIVE → DL_INIT with a TLP held:** the beat is held until pipe_txready_i. No new TLP grants are issued.

## Timing
- Reset values: pipe_txdata_o = 0, pipe_txvalid_o = 0, pipe_txkind_o = 0, tlp_seq_o = 0, next_seq_o = 0, burst_cnt = 0. tlp_ready_o and dllp_ready_o are 0 during reset.
- Grant → pipe_txvalid_o: 1 cycle latency (registered output).
- Full throughput of one beat per cycle while pipe_txready_i stays high.
- tlp_ready_o and dllp_ready_o are combinational from the valids, dlc_state_i, pipe_txvalid_o, pipe_txready_i and burst_cnt. There is no combinational path from pipe_txready_i to pipe_txdata_o.
- Stall: pipe_txdata_o, pipe_txkind_o and tlp_seq_o hold while pipe_txvalid_o && !pipe_txready_i.
- Simultaneous load and drain: when the PHY accepts and a new grant occurs in the same cycle, the new beat appears in the next cycle with no bubble.

## Structure
- Shared package dll_pkg holds:
  - dlc_state_e (DL_INACTIVE, DL_FEATURE, DL_INIT, DL_ACTIVE)
  - TX_KIND_TLP / TX_KIND_DLLP
  - frame-width localparams (TLP_W = 128, DLLP_W = 32, PIPE_W = 136)
- dll_pkg is also consumed by the DLCMSM.
- One sub-module is natural: dll_tx_arb, which contains the burst-limited priority arbiter and burst_cnt. Framing, sequencing and the output register stay in the top.

## Test plan
- Reset, then DL_ACTIVE with a TLP 128'hA5…, pipe_txready_i = 1 → next cycle: pipe_txdata_o = {128'hA5…, 8'h00}, kind = 0, tlp_seq_o = 0, next_seq_o = 1.
- DL_INIT with TLP and DLLP 32'hDEADBEEF both valid → only DLLP granted: data[135:104] = DEADBEEF, kind = 1. tlp_ready_o stays 0.
- DL_ACTIVE with TLP and DLLP continuously valid, MAX_TLP_BURST = 4 → grant pattern T,T,T,T,D repeating. Sequence numbers increment on T only.
- pipe_txready_i low for 3 cycles with a beat held → outputs stable, both readies 0. Ready high → next grant, with no beat lost or duplicated.
- Issue 4097 TLPs → tlp_seq_o wraps 4095 → 0 → 0 (the last two TLPs carry 4095 then 0 at the wrap), next_seq_o = 1 after the last.
- Beat held under stall, then dlc_state_i = DL_INACTIVE → pipe_txvalid_o = 0 next cycle, next_seq_o = 0, no readies. Return to DL_ACTIVE → next TLP carries seq 0.
